// File: rtl/sys_array_pkg.sv
// Shared types and width helpers for the systolic-array result drain.
package sys_array_pkg;

  typedef enum logic [0:0] {
    IDLE,
    STREAM
  } drain_state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Index width for a dimension of n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int result_width(input int dw);
    return 2 * dw;
  endfunction

  typedef logic [result_width(DEFAULT_DATA_WIDTH)-1:0] result_t;

endpackage

// File: rtl/sys_array_index_counter.sv
// Two-level wrap counter: inner runs 0..inner_max, then outer steps; both wrap after the last pair.
module sys_array_index_counter
  import sys_array_pkg::*;
#(
  parameter int INNER_WIDTH = 1,
  parameter int OUTER_WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   advance,
  input  logic [INNER_WIDTH-1:0] inner_max,
  input  logic [OUTER_WIDTH-1:0] outer_max,
  output logic [INNER_WIDTH-1:0] inner,
  output logic [OUTER_WIDTH-1:0] outer,
  output logic                   at_last
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inner <= '0;
      outer <= '0;
    end else if (clear) begin
      inner <= '0;
      outer <= '0;
    end else if (advance) begin
      if (inner == inner_max) begin
        inner <= '0;
        outer <= (outer == outer_max) ? '0 : outer + OUTER_WIDTH'(1);
      end else begin
        inner <= inner + INNER_WIDTH'(1);
      end
    end
  end

  assign at_last = (inner == inner_max) && (outer == outer_max);

endmodule

// File: rtl/sys_array_result_drain.sv
// Captures the fetcher's result matrix on a rising res_valid and streams it out element by element.
// Define SYS_ARRAY_DRAIN_COL_MAJOR_EN for column-major order; row-major otherwise.
module sys_array_result_drain
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W_W  = 5,
  parameter int ARRAY_A_L  = 6
) (
  input  logic                                                  clk,
  input  logic                                                  reset_n,
  input  logic                                                  res_valid,
  input  logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][2*DATA_WIDTH-1:0] res_data,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic [2*DATA_WIDTH-1:0]                               out_data,
  output logic [idx_width(ARRAY_W_W)-1:0]                       out_row,
  output logic [idx_width(ARRAY_A_L)-1:0]                       out_col,
  output logic                                                  out_last,
  output logic                                                  busy,
  output logic                                                  done,
  output logic                                                  overrun
);

  localparam int ROW_W = idx_width(ARRAY_W_W);
  localparam int COL_W = idx_width(ARRAY_A_L);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ARRAY_W_W - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(ARRAY_A_L - 1);

  drain_state_t state, next_state;
  logic res_valid_q;
  logic res_edge;
  logic capture;
  logic handshake;
  logic at_last;
  logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][2*DATA_WIDTH-1:0] buffer;

  assign res_edge  = res_valid & ~res_valid_q;
  assign capture   = (state == IDLE) & res_edge;
  assign out_valid = (state == STREAM);
  assign handshake = out_valid & out_ready;
  assign busy      = (state != IDLE);
  assign out_last  = at_last & out_valid;
  assign out_data  = buffer[out_row][out_col];

`ifdef SYS_ARRAY_DRAIN_COL_MAJOR_EN
  sys_array_index_counter #(
    .INNER_WIDTH(ROW_W),
    .OUTER_WIDTH(COL_W)
  ) u_index (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (capture),
    .advance  (handshake),
    .inner_max(ROW_MAX),
    .outer_max(COL_MAX),
    .inner    (out_row),
    .outer    (out_col),
    .at_last  (at_last)
  );
`else
  sys_array_index_counter #(
    .INNER_WIDTH(COL_W),
    .OUTER_WIDTH(ROW_W)
  ) u_index (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (capture),
    .advance  (handshake),
    .inner_max(COL_MAX),
    .outer_max(ROW_MAX),
    .inner    (out_col),
    .outer    (out_row),
    .at_last  (at_last)
  );
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      res_valid_q <= 1'b0;
      buffer      <= '0;
      done        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= next_state;
      res_valid_q <= res_valid;
      done        <= handshake & at_last;
      if (capture) begin
        buffer <= res_data;
      end
      // An edge arriving while a matrix is still held is dropped, including on the final handshake.
      if (res_edge && state == STREAM) begin
        overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (res_edge) next_state = STREAM;
      STREAM:  if (handshake && at_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

endmodule
